// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
//
// slot_t describes one in-flight writer in the scoreboard. Its dst field is
// sized for the widest register address supported (REG_W_MAX). Narrower
// configurations zero-extend into it, so the same packed layout works for
// every REG_W up to that limit.
package fwd_pkg;

  localparam int REG_W_MAX = 8;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] dst;
    logic                 wen;
    logic                 memToReg;
  } slot_t;

  localparam int SLOT_W = $bits(slot_t);

  // Forward-select encodings for the default three-deep scoreboard.
  localparam int FWD_NONE = 0;
  localparam int FWD_EX   = 1;
  localparam int FWD_MEM  = 2;
  localparam int FWD_WB   = 3;

  // A slot can supply a value only if it really writes a non-zero register.
  function automatic logic isLive(input slot_t s);
    return s.valid & s.wen & (s.dst != '0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-source priority matcher.
//
// Scans the scoreboard for the youngest live slot whose destination equals
// the source register and reports where to forward from.
//
// Ports:
//   slotVec  in   STAGES packed slot_t entries, slot k at [k*SLOT_W +: SLOT_W]
//   src      in   source register address
//   sel      out  0 = register file, k+1 = forward from slot k
//   load     out  selected slot carries load data (1) or an ALU result (0)
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int STAGES = 3,
  parameter int SEL_W  = 3
) (
  input  logic [STAGES*SLOT_W-1:0] slotVec,
  input  logic [REG_W-1:0]         src,
  output logic [SEL_W-1:0]         sel,
  output logic                     load
);

  logic [REG_W_MAX-1:0] srcExt;
  slot_t                cur;

  assign srcExt = REG_W_MAX'(src);

  // Walk from the oldest slot to the youngest so a younger match overwrites
  // an older one; the last hit standing is the lowest k.
  always_comb begin
    sel  = '0;
    load = 1'b0;
    cur  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      cur = slot_t'(slotVec[k*SLOT_W +: SLOT_W]);
      if ((src != '0) && isLive(cur) && (cur.dst == srcExt)) begin
        sel  = SEL_W'(k + 1);
        load = cur.memToReg;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the pipelined MIPS core.
//
// Tracks in-flight register writers in a shift-register scoreboard (slot 0 =
// EX, slot 1 = MEM, slot 2 = WB for the default depth), derives per-source
// forward selects from it, and raises a one-cycle stall when the decode
// instruction needs the result of a load that is still in EX.
//
// Ports:
//   clk            in   core clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   id_valid       in   valid instruction in decode
//   id_dst         in   destination register of the decode instruction
//   id_wen         in   decode instruction writes the register file
//   id_mem_to_reg  in   decode instruction is a load
//   id_src         in   NUM_SRC source registers, source i at [i*REG_W +: REG_W]
//   flush          in   squash the decode instruction (branch / jump)
//   fwd_sel        out  per source: 0 = register file, k+1 = slot k
//   fwd_load       out  per source: selected slot holds load data
//   stall          out  load-use hazard, hold PC and IF/ID
//   stall_cnt      out  saturating count of stall cycles
//
// STAGES must be 2..7, SEL_W >= clog2(STAGES+1), REG_W <= fwd_pkg::REG_W_MAX.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int STAGES  = 3,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 3,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [REG_W-1:0]         id_dst,
  input  logic                     id_wen,
  input  logic                     id_mem_to_reg,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic [NUM_SRC-1:0]       fwd_load,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cnt
);

  // Scoreboard fields. Only the valid bits carry reset; the payload is
  // meaningless while valid is low, so it is left unreset.
  logic [STAGES-1:0] slotVld;
  logic [STAGES-1:0] slotWen;
  logic [STAGES-1:0] slotLoad;
  logic [REG_W-1:0]  slotDst [STAGES];

  logic [STAGES*SLOT_W-1:0] slotVec;
  slot_t                    packSlot;

  logic                     slot0LiveLoad;
  logic [NUM_SRC-1:0]       srcHit0;
  logic                     take;
  logic [CNT_W-1:0]         stallCntQ;

  // Pack the scoreboard into the shared slot layout for the matchers.
  always_comb begin
    slotVec  = '0;
    packSlot = '0;
    for (int k = 0; k < STAGES; k++) begin
      packSlot.valid    = slotVld[k];
      packSlot.dst      = REG_W_MAX'(slotDst[k]);
      packSlot.wen      = slotWen[k];
      packSlot.memToReg = slotLoad[k];
      slotVec[k*SLOT_W +: SLOT_W] = packSlot;
    end
  end

  // Load-use detection: only a load still in EX is too late to forward.
  always_comb begin
    slot0LiveLoad = slotVld[0] & slotWen[0] & slotLoad[0] & (slotDst[0] != '0);
    srcHit0       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      srcHit0[i] = (id_src[i*REG_W +: REG_W] != '0) &&
                   (id_src[i*REG_W +: REG_W] == slotDst[0]);
    end
    stall = id_valid & slot0LiveLoad & (|srcHit0);
  end

  // A stalled or flushed instruction becomes a bubble; the stall is still
  // reported on a flush because fetch has to hold regardless.
  assign take = id_valid & ~stall & ~flush;

  // ---- decode -> scoreboard slot 0, slot k -> slot k+1 ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotVld   <= '0;
      stallCntQ <= '0;
    end else begin
      slotVld <= {slotVld[STAGES-2:0], take};
      if (stall && (stallCntQ != '1)) begin
        stallCntQ <= stallCntQ + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    slotWen    <= {slotWen[STAGES-2:0], id_wen};
    slotLoad   <= {slotLoad[STAGES-2:0], id_mem_to_reg};
    slotDst[0] <= id_dst;
    for (int k = 1; k < STAGES; k++) begin
      slotDst[k] <= slotDst[k-1];
    end
  end

  assign stall_cnt = stallCntQ;

  for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
    fwd_match #(
      .REG_W  (REG_W),
      .STAGES (STAGES),
      .SEL_W  (SEL_W)
    ) uMatch (
      .slotVec (slotVec),
      .src     (id_src[i*REG_W +: REG_W]),
      .sel     (fwd_sel[i*SEL_W +: SEL_W]),
      .load    (fwd_load[i])
    );
  end

endmodule
